// File: rtl/debounce_pkg.sv
// debounce_pkg: shared defaults, counter sizing and per-channel edge encoding for the debouncers
package debounce_pkg;
  localparam int DEF_STABLE_CYCLES = 16;
  localparam int DEF_SYNC_STAGES = 2;
  typedef enum logic [1:0] {EDGE_NONE, EDGE_RISE, EDGE_FALL} edge_e;
  function automatic int cnt_width(input int stable);
    return $clog2(stable + 1);
  endfunction
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one-bit synchroniser, stability counter, accepted level and edge pulses
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int   STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int   SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter logic RST_VAL       = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_data,
  input  logic i_tick,
  output logic o_data,
  output logic o_rise,
  output logic o_fall,
  output logic o_pend
);
  localparam int CNT_W = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0] cnt;
  logic s;
  logic diff;
  edge_e edge_nxt;
  always_comb begin
    s = sync[SYNC_STAGES-1];
    diff = s != o_data;
    edge_nxt = (diff && i_tick && cnt == CNT_LAST) ? (s ? EDGE_RISE : EDGE_FALL) : EDGE_NONE;
    o_pend = edge_nxt != EDGE_NONE;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync   <= {SYNC_STAGES{RST_VAL}};
      cnt    <= '0;
      o_data <= RST_VAL;
      o_rise <= 1'b0;
      o_fall <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], i_data};
      o_rise <= edge_nxt == EDGE_RISE;
      o_fall <= edge_nxt == EDGE_FALL;
      if (o_pend) o_data <= s;
      cnt    <= (!diff || o_pend) ? '0 : i_tick ? cnt + CNT_W'(1) : cnt;
    end
  end
endmodule

// File: rtl/multi_debouncer.sv
// multi_debouncer: N_CH independent debounce channels with a shared registered any-change flag
module multi_debouncer
  import debounce_pkg::*;
#(
  parameter int   N_CH          = 4,
  parameter int   STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int   SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter logic RST_VAL       = 1'b0
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [N_CH-1:0] i_data,
  input  logic            i_tick,
  output logic [N_CH-1:0] o_data,
  output logic [N_CH-1:0] o_rise,
  output logic [N_CH-1:0] o_fall,
  output logic            o_any_change
);
  logic [N_CH-1:0] pend;
  genvar c;
  generate
    for (c = 0; c < N_CH; c++) begin : g_ch
      debounce_channel #(
        .STABLE_CYCLES(STABLE_CYCLES),
        .SYNC_STAGES  (SYNC_STAGES),
        .RST_VAL      (RST_VAL)
      ) u_ch (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_data (i_data[c]),
        .i_tick (i_tick),
        .o_data (o_data[c]),
        .o_rise (o_rise[c]),
        .o_fall (o_fall[c]),
        .o_pend (pend[c])
      );
    end
  endgenerate
  // registered from the same next-edge terms so it lines up with the pulse bits
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_any_change <= 1'b0;
    else          o_any_change <= |pend;
  end
endmodule

// File: tb/tb_multi_debouncer.sv
// tb_multi_debouncer: directed stimulus with a pulse scoreboard for multi_debouncer
module tb_multi_debouncer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] din = 4'h0;
  logic       tick = 1'b1;
  logic [3:0] o_data, o_rise, o_fall;
  logic       o_any;
  logic       tick_mode = 1'b0;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  logic [3:0] acc = 4'h0;

  typedef struct {int at; logic [3:0] r; logic [3:0] f; logic [3:0] d;} ev_t;
  ev_t q[$];

  multi_debouncer #(.N_CH(4), .STABLE_CYCLES(8), .SYNC_STAGES(2), .RST_VAL(1'b0)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(din), .i_tick(tick),
    .o_data(o_data), .o_rise(o_rise), .o_fall(o_fall), .o_any_change(o_any)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) tick = tick_mode ? ((cyc + 1) % 4 == 0) : 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int at, input logic [3:0] r, input logic [3:0] f, input logic [3:0] d);
    ev_t e;
    e.at = at; e.r = r; e.f = f; e.d = d;
    q.push_back(e);
  endtask

  task automatic align4();
    for (int i = 0; i < 8 && cyc % 4 != 0; i++) wait_cyc(1);
  endtask

  always @(negedge clk) begin
    if (o_any || |o_rise || |o_fall) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_pulse rise=%0h fall=%0h any=%0b (cycle %0d)", o_rise, o_fall, o_any, cyc);
      end else begin
        ev_t e;
        e = q.pop_front();
        chk("pulse_cycle", cyc, e.at);
        chk("rise", {28'd0, o_rise}, {28'd0, e.r});
        chk("fall", {28'd0, o_fall}, {28'd0, e.f});
        chk("any_change", {31'd0, o_any}, 32'd1);
        chk("data_at_pulse", {28'd0, o_data}, {28'd0, e.d});
        chk("rise_fall_excl", {28'd0, o_rise & o_fall}, 32'd0);
      end
    end
  end

  initial begin
    int k;
    #1;
    chk("por_data", {28'd0, o_data}, 32'd0);
    chk("por_pulses", {24'd0, o_rise, o_fall}, 32'd0);
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(5);
    // clean step on channel 0
    k = cyc; din[0] = 1'b1; acc[0] = 1'b1;
    push(k + 10, 4'h1, 4'h0, acc);
    wait_cyc(9);
    chk("step_not_early", {31'd0, o_data[0]}, 32'd0);
    wait_cyc(11);
    chk("step_level", {28'd0, o_data}, 32'h1);
    // 7-cycle glitch rejected, 8-cycle excursion accepted then released
    din[1] = 1'b1; wait_cyc(7); din[1] = 1'b0;
    wait_cyc(20);
    chk("glitch7_level", {31'd0, o_data[1]}, 32'd0);
    k = cyc; din[1] = 1'b1; wait_cyc(8); din[1] = 1'b0;
    acc[1] = 1'b1; push(k + 10, 4'h2, 4'h0, acc);
    acc[1] = 1'b0; push(k + 18, 4'h0, 4'h2, acc);
    wait_cyc(25);
    // chatter on channel 2, final level 1
    for (int i = 0; i < 13; i++) begin
      k = cyc; din[2] = ~din[2]; wait_cyc(3);
    end
    acc[2] = 1'b1; push(k + 10, 4'h4, 4'h0, acc);
    wait_cyc(20);
    chk("chatter_level", {28'd0, o_data}, 32'h5);
    // tick prescale 1-in-4 on channel 3
    tick_mode = 1'b1;
    wait_cyc(2); align4();
    din[3] = 1'b1; wait_cyc(12); din[3] = 1'b0;
    wait_cyc(30);
    chk("tick_early_return", {31'd0, o_data[3]}, 32'd0);
    align4();
    k = cyc; din[3] = 1'b1;
    acc[3] = 1'b1; push(k + 32, 4'h8, 4'h0, acc);
    wait_cyc(31);
    chk("tick_not_early", {31'd0, o_data[3]}, 32'd0);
    wait_cyc(9);
    tick_mode = 1'b0;
    wait_cyc(2);
    // simultaneous fall of ch0/2/3, then simultaneous rise of all
    k = cyc; din = 4'h0; acc = 4'h0; push(k + 10, 4'h0, 4'hD, acc);
    wait_cyc(20);
    k = cyc; din = 4'hF; acc = 4'hF; push(k + 10, 4'hF, 4'h0, acc);
    wait_cyc(15);
    // asynchronous reset with inputs high
    rst_n = 1'b0;
    #1;
    chk("async_rst_data", {28'd0, o_data}, 32'd0);
    chk("async_rst_pulses", {24'd0, o_rise, o_fall}, 32'd0);
    chk("async_rst_any", {31'd0, o_any}, 32'd0);
    wait_cyc(3);
    k = cyc; rst_n = 1'b1; push(k + 10, 4'hF, 4'h0, 4'hF);
    wait_cyc(20);
    // reset at count 5 discards progress
    k = cyc; din = 4'h0; push(k + 10, 4'h0, 4'hF, 4'h0);
    wait_cyc(20);
    din = 4'hF; wait_cyc(7);
    rst_n = 1'b0; wait_cyc(3);
    k = cyc; rst_n = 1'b1; push(k + 10, 4'hF, 4'h0, 4'hF);
    wait_cyc(9);
    chk("requal_not_early", {28'd0, o_data}, 32'd0);
    for (int i = 0; i < 50 && q.size() != 0; i++) wait_cyc(1);
    while (q.size() != 0) begin
      ev_t e;
      e = q.pop_front();
      total++; bad++;
      $display("FAIL missing_pulse got=none want=rise %0h fall %0h at cycle %0d", e.r, e.f, e.at);
    end
    wait_cyc(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multi_debouncer.md
Name: multi_debouncer

Overview:
- Parametrised, multi-channel successor to the single-bit debouncer, for mechanical buttons and switches.
- Each of N_CH asynchronous inputs is synchronised and then accepted only after it has been stable for STABLE_CYCLES qualified cycles.
- Outputs per channel: a clean level plus single-cycle rise and fall pulses, for consumption by control FSMs.
- An optional tick input slows the qualification rate without a wider counter.

Parameters:
- N_CH, 4: number of independent channels (1..32).
- STABLE_CYCLES, 16: consecutive qualified cycles of stable input required to accept a new level (>=2).
- SYNC_STAGES, 2: synchroniser flip-flop depth (2..4).
- RST_VAL, 0: 1-bit reset level of the synchroniser chain and o_data, applied to all channels.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_data  in  N_CH  raw asynchronous inputs.
- i_tick  in  1  qualification enable; tie to 1 for per-clock counting.
- o_data  out  N_CH  debounced levels.
- o_rise  out  N_CH  one-cycle pulse when o_data goes 0->1.
- o_fall  out  N_CH  one-cycle pulse when o_data goes 1->0.
- o_any_change  out  1  OR of all o_rise and o_fall bits, registered with them.

Behaviour:
- Reset, while i_rst_n=0 (asynchronous):
  - All synchroniser stages = RST_VAL.
  - o_data = {N_CH{RST_VAL}}.
  - Counters = 0.
  - o_rise = 0, o_fall = 0, o_any_change = 0.
- Reset release is synchronous to i_clk (deassertion expected to be pre-synchronised upstream). The first counting edge is the first edge with i_rst_n=1.
- Synchroniser: per channel, a SYNC_STAGES-deep shift register. Its last stage is s. No logic acts on the raw input.
- Counter: per channel, width CNT_W = $clog2(STABLE_CYCLES+1). Per channel, at each edge:
  - s == o_data: counter := 0.
  - s != o_data and i_tick=0: counter holds.
  - s != o_data, i_tick=1 and counter < STABLE_CYCLES-1: counter := counter+1.
  - s != o_data, i_tick=1 and counter == STABLE_CYCLES-1:
    - o_data := s and counter := 0.
    - o_rise or o_fall := 1 for exactly that one cycle, depending on direction.
- Latency with i_tick=1: o_data changes at the (SYNC_STAGES+STABLE_CYCLES)-th edge after the first edge that samples the new input level. Default values give 18 cycles.
- Glitch rejection: any excursion whose s-level lasts fewer than STABLE_CYCLES qualified cycles leaves o_data unchanged and produces no pulse. A return to the accepted level clears the counter immediately.
- Chatter: each toggle back to the accepted level restarts qualification from 0. The counter never saturates or wraps.
- Pulses:
  - o_rise and o_fall are never high together on the same channel.
  - Pulses are registered, aligned with the o_data update, and low on every other cycle.
- Channels are fully independent. Simultaneous acceptance on several channels asserts several pulse bits in the same cycle; o_any_change is high for that one cycle.
- Reset mid-count: counts are discarded, outputs return to reset values, and no pulse is generated by the reset itself.
- If i_data differs from RST_VAL at reset release: after qualification, a normal edge pulse is produced. This is intended, not suppressed.

Decomposition:
- Package debounce_pkg holds:
  - function cnt_width(stable) returning $clog2(stable+1);
  - localparam defaults DEF_STABLE_CYCLES and DEF_SYNC_STAGES;
  - enum edge_e {EDGE_NONE, EDGE_RISE, EDGE_FALL}, used internally per channel.
- Sub-module debounce_channel: one bit with synchroniser, counter, level register and edge outputs. It is instantiated N_CH times in a generate loop. The top level builds o_any_change.

Test Plan:
- Reset: i_rst_n=0 asserted mid-run with i_data=4'hF -> o_data=4'h0, o_rise=o_fall=0 asynchronously, without waiting for a clock edge.
- Clean step: N_CH=4, STABLE_CYCLES=8, i_tick=1, i_data[0] 0->1 held -> o_data[0]=1 exactly 10 edges later, o_rise[0] and o_any_change high for 1 cycle, other channels unchanged.
- Glitch: i_data[1] high for 7 cycles then low -> o_data[1] stays 0, no pulses. Repeat with 8 cycles -> accepted.
- Chatter: i_data[2] toggles every 3 cycles for 40 cycles, then holds 1 -> single o_rise[2], 10 cycles after the final transition.
- Tick prescale: i_tick high 1 cycle in 4, i_data[3] 1 held -> acceptance after 8 tick cycles (about 32 clocks). A 1->0 return before then yields no o_fall[3].
- Simultaneous plus reset mid-count: i_data 0->4'hF together -> all four o_rise bits in the same cycle. Pulling i_rst_n low at count 5 -> no pulse, and after release a full 10-cycle requalification is required.
